// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg
// Shared definitions for the ALU operation sequencer:
//   - command op codes (ALU single pass, 8-bit add, 8-bit subtract, 4x4 multiply)
//   - select encodings understood by the team's 4-bit ALU
//   - the sequencer FSM state enum
package alu_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_ALU  = 2'b00,
    OP_ADD8 = 2'b01,
    OP_SUB8 = 2'b10,
    OP_MUL  = 2'b11
  } op_e;

  // Arithmetic selects
  localparam logic [3:0] SEL_PASS = 4'b0000;  // x
  localparam logic [3:0] SEL_ADD  = 4'b0010;  // x + y
  localparam logic [3:0] SEL_ADDC = 4'b0011;  // x + y + 1
  localparam logic [3:0] SEL_SUBB = 4'b0100;  // x + ~y (subtract with borrow pending)
  localparam logic [3:0] SEL_SUB  = 4'b0101;  // x - y
  // Logic selects
  localparam logic [3:0] SEL_AND  = 4'b1000;
  localparam logic [3:0] SEL_OR   = 4'b1001;
  localparam logic [3:0] SEL_XOR  = 4'b1010;
  localparam logic [3:0] SEL_NOT  = 4'b1011;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EXEC_LO = 3'd1,
    ST_EXEC_HI = 3'd2,
    ST_MUL     = 3'd3,
    ST_RESP    = 3'd4
  } state_e;

endpackage

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
// Command-driven controller that steers an external 4-bit ALU through one or
// more passes to produce an 8-bit result. The ALU itself sits beside this block
// in the parent; all data arithmetic happens there.
//
// Ports:
//   clk, reset_n            clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready     command handshake; ready only while idle
//   cmd_op, cmd_sel,        op code (ALU/ADD8/SUB8/MUL), ALU select for ALU op,
//   cmd_cin, cmd_a, cmd_b   carry-in for ADD8, 8-bit operands
//   rsp_valid/rsp_ready     response handshake
//   rsp_data, rsp_carry     8-bit result and final ALU carry (MUL: 0)
//   alu_x, alu_y, alu_sel   drive to the ALU (zero when not executing)
//   alu_out, alu_cout       result back from the ALU
module alu_op_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int DW = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_op,
  input  logic [3:0]      cmd_sel,
  input  logic            cmd_cin,
  input  logic [2*DW-1:0] cmd_a,
  input  logic [2*DW-1:0] cmd_b,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [2*DW-1:0] rsp_data,
  output logic            rsp_carry,
  output logic [DW-1:0]   alu_x,
  output logic [DW-1:0]   alu_y,
  output logic [3:0]      alu_sel,
  input  logic [DW-1:0]   alu_out,
  input  logic            alu_cout
);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [3:0]        sel_q, sel_d;
  logic              cin_q, cin_d;
  logic [2*DW-1:0]   a_q, a_d;
  logic [2*DW-1:0]   b_q, b_d;
  logic [DW-1:0]     lo_q, lo_d;
  logic              c_q, c_d;
  logic [DW-1:0]     acc_hi_q, acc_hi_d;
  logic [DW-1:0]     acc_lo_q, acc_lo_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [2*DW-1:0]   rsp_data_q, rsp_data_d;
  logic              rsp_carry_q, rsp_carry_d;

  // Shift-add step: the ALU adds the multiplicand into the upper half only
  // when the current multiplier bit is set, then the whole accumulator
  // shifts right by one, pulling the carry in at the top.
  logic [2*DW-1:0]   mul_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_ALU;
      sel_q       <= '0;
      cin_q       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      lo_q        <= '0;
      c_q         <= 1'b0;
      acc_hi_q    <= '0;
      acc_lo_q    <= '0;
      cnt_q       <= '0;
      rsp_data_q  <= '0;
      rsp_carry_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      sel_q       <= sel_d;
      cin_q       <= cin_d;
      a_q         <= a_d;
      b_q         <= b_d;
      lo_q        <= lo_d;
      c_q         <= c_d;
      acc_hi_q    <= acc_hi_d;
      acc_lo_q    <= acc_lo_d;
      cnt_q       <= cnt_d;
      rsp_data_q  <= rsp_data_d;
      rsp_carry_q <= rsp_carry_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    sel_d       = sel_q;
    cin_d       = cin_q;
    a_d         = a_q;
    b_d         = b_q;
    lo_d        = lo_q;
    c_d         = c_q;
    acc_hi_d    = acc_hi_q;
    acc_lo_d    = acc_lo_q;
    cnt_d       = cnt_q;
    rsp_data_d  = rsp_data_q;
    rsp_carry_d = rsp_carry_q;
    cmd_ready   = 1'b0;
    alu_x       = '0;
    alu_y       = '0;
    alu_sel     = SEL_PASS;
    mul_next    = {alu_cout & acc_lo_q[0], alu_out, acc_lo_q[DW-1:1]};

    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          op_d  = op_e'(cmd_op);
          sel_d = cmd_sel;
          cin_d = cmd_cin;
          a_d   = cmd_a;
          b_d   = cmd_b;
          if (op_e'(cmd_op) == OP_MUL) begin
            acc_hi_d = '0;
            acc_lo_d = cmd_a[DW-1:0];
            cnt_d    = '0;
            state_d  = ST_MUL;
          end else begin
            state_d  = ST_EXEC_LO;
          end
        end
      end

      ST_EXEC_LO: begin
        alu_x = a_q[DW-1:0];
        alu_y = b_q[DW-1:0];
        case (op_q)
          OP_ALU:  alu_sel = sel_q;
          OP_ADD8: alu_sel = {SEL_ADD[3:1], cin_q};
          OP_SUB8: alu_sel = SEL_SUB;
          default: alu_sel = SEL_PASS;
        endcase
        lo_d = alu_out;
        c_d  = alu_cout;
        if (op_q == OP_ALU) begin
          rsp_data_d  = {{DW{1'b0}}, alu_out};
          rsp_carry_d = alu_cout;
          state_d     = ST_RESP;
        end else begin
          state_d     = ST_EXEC_HI;
        end
      end

      ST_EXEC_HI: begin
        // The low-nibble carry chains into the high pass; for subtract a
        // carry of 1 means no borrow, so x-y, otherwise x+~y.
        alu_x = a_q[2*DW-1:DW];
        alu_y = b_q[2*DW-1:DW];
        if (op_q == OP_SUB8) begin
          alu_sel = {SEL_SUBB[3:1], c_q};
        end else begin
          alu_sel = {SEL_ADD[3:1], c_q};
        end
        rsp_data_d  = {alu_out, lo_q};
        rsp_carry_d = alu_cout;
        state_d     = ST_RESP;
      end

      ST_MUL: begin
        alu_x = acc_hi_q;
        alu_y = b_q[DW-1:0];
        alu_sel = acc_lo_q[0] ? SEL_ADD : SEL_PASS;
        {acc_hi_d, acc_lo_d} = mul_next;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          rsp_data_d  = mul_next;
          rsp_carry_d = 1'b0;
          state_d     = ST_RESP;
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_carry = rsp_carry_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer
// Drives directed and random commands into alu_op_sequencer, plays the part of
// the parent by modelling the 4-bit ALU, and compares every response, the
// per-cycle select sequence and the handshake behaviour against a plain
// arithmetic reference.
module tb_alu_op_sequencer;

  logic       clk;
  logic       reset_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_sel;
  logic       cmd_cin;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_carry;
  logic [3:0] alu_x;
  logic [3:0] alu_y;
  logic [3:0] alu_sel;
  logic [3:0] alu_out;
  logic       alu_cout;

  int testCount = 0;
  int failCount = 0;

  logic [3:0] validSels [9] = '{4'b0000, 4'b0010, 4'b0011, 4'b0100, 4'b0101,
                                4'b1000, 4'b1001, 4'b1010, 4'b1011};

  alu_op_sequencer #(.DW(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_sel   (cmd_sel),
    .cmd_cin   (cmd_cin),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_carry (rsp_carry),
    .alu_x     (alu_x),
    .alu_y     (alu_y),
    .alu_sel   (alu_sel),
    .alu_out   (alu_out),
    .alu_cout  (alu_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 4-bit ALU: returns {cout, out}.
  function automatic logic [4:0] aluModel(input logic [3:0] sel, input logic [3:0] x, input logic [3:0] y);
    logic [4:0] r;
    case (sel)
      4'b0000: r = {1'b0, x};
      4'b0010: r = {1'b0, x} + {1'b0, y};
      4'b0011: r = {1'b0, x} + {1'b0, y} + 5'd1;
      4'b0100: r = {1'b0, x} + {1'b0, ~y};
      4'b0101: r = {1'b0, x} + {1'b0, ~y} + 5'd1;
      4'b1000: r = {1'b0, x & y};
      4'b1001: r = {1'b0, x | y};
      4'b1010: r = {1'b0, x ^ y};
      4'b1011: r = {1'b0, ~x};
      default: r = 5'd0;
    endcase
    return r;
  endfunction

  always_comb {alu_cout, alu_out} = aluModel(alu_sel, alu_x, alu_y);

  // Reference result {carry, data} computed directly from the operation.
  function automatic logic [8:0] refResult(input logic [1:0] op, input logic [3:0] sel,
                                           input logic cin, input logic [7:0] a, input logic [7:0] b);
    logic [4:0] r;
    logic [8:0] res;
    case (op)
      2'b00: begin
        r   = aluModel(sel, a[3:0], b[3:0]);
        res = {r[4], 4'b0000, r[3:0]};
      end
      2'b01: res = {1'b0, a} + {1'b0, b} + {8'd0, cin};
      2'b10: res = {(a >= b), 8'(a - b)};
      default: res = {1'b0, 8'(a[3:0] * b[3:0])};
    endcase
    return res;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Keep cmd_valid high with junk fields while the block is busy; none of it
  // may be accepted.
  task automatic driveJunk();
    cmd_valid = 1'b1;
    cmd_op    = 2'($urandom_range(0, 3));
    cmd_sel   = 4'($urandom_range(0, 15));
    cmd_cin   = 1'($urandom_range(0, 1));
    cmd_a     = 8'($urandom_range(0, 255));
    cmd_b     = 8'($urandom_range(0, 255));
  endtask

  // Runs one full command: accept, execution cycles, response with stall
  // cycles of backpressure, handshake and the idle bubble after it.
  task automatic applyStimulus(input logic [1:0] op, input logic [3:0] sel, input logic cin,
                               input logic [7:0] a, input logic [7:0] b, input int stall);
    logic [3:0] expSel [4];
    int         nSel;
    int         expLat;
    int         lat;
    logic [8:0] expRes;

    expRes = refResult(op, sel, cin, a, b);
    case (op)
      2'b00: begin nSel = 1; expLat = 1; expSel[0] = sel; end
      2'b01: begin
        nSel = 2; expLat = 2;
        expSel[0] = {3'b001, cin};
        expSel[1] = {3'b001, ({1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'd0, cin}) > 5'd15};
      end
      2'b10: begin
        nSel = 2; expLat = 2;
        expSel[0] = 4'b0101;
        expSel[1] = {3'b010, (a[3:0] >= b[3:0])};
      end
      default: begin
        nSel = 4; expLat = 4;
        for (int i = 0; i < 4; i++) expSel[i] = a[i] ? 4'b0010 : 4'b0000;
      end
    endcase

    @(negedge clk);
    checkOutput("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_sel   = sel;
    cmd_cin   = cin;
    cmd_a     = a;
    cmd_b     = b;
    rsp_ready = 1'b0;
    @(negedge clk);
    driveJunk();
    checkOutput("first_alu_y", 32'(alu_y), 32'(b[3:0]));
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      if (lat < nSel) checkOutput("alu_sel_seq", 32'(alu_sel), 32'(expSel[lat]));
      checkOutput("cmd_ready_busy", 32'(cmd_ready), 32'd0);
      @(negedge clk);
      driveJunk();
      lat++;
    end
    checkOutput("latency", 32'(lat), 32'(expLat));
    checkOutput("rsp_data", 32'(rsp_data), 32'(expRes[7:0]));
    checkOutput("rsp_carry", 32'(rsp_carry), 32'(expRes[8]));
    checkOutput("alu_sel_resp", 32'(alu_sel), 32'd0);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      driveJunk();
      checkOutput("stall_valid", 32'(rsp_valid), 32'd1);
      checkOutput("stall_data", 32'({rsp_carry, rsp_data}), 32'(expRes));
      checkOutput("stall_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    checkOutput("post_hs_valid", 32'(rsp_valid), 32'd0);
    checkOutput("post_hs_ready", 32'(cmd_ready), 32'd1);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    checkOutput({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    checkOutput({tag, "_rsp_data"}, 32'({rsp_carry, rsp_data}), 32'd0);
    checkOutput({tag, "_alu_drive"}, 32'({alu_x, alu_y, alu_sel}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_sel   = 4'b0000;
    cmd_cin   = 1'b0;
    cmd_a     = 8'h00;
    cmd_b     = 8'h00;
    rsp_ready = 1'b0;
    #12;
    checkResetValues("reset");
    @(negedge clk);
    reset_n = 1'b1;

    applyStimulus(2'b00, 4'b0101, 1'b0, 8'h07, 8'h03, 0);
    applyStimulus(2'b01, 4'b0000, 1'b0, 8'h9C, 8'h78, 1);
    applyStimulus(2'b10, 4'b0000, 1'b0, 8'h30, 8'h45, 0);
    applyStimulus(2'b11, 4'b0000, 1'b0, 8'h0F, 8'h0F, 0);
    applyStimulus(2'b11, 4'b0000, 1'b0, 8'h00, 8'h09, 0);
    applyStimulus(2'b01, 4'b0000, 1'b1, 8'hFF, 8'h00, 5);

    for (int t = 0; t < 40; t++) begin
      applyStimulus(2'($urandom_range(0, 3)), validSels[$urandom_range(0, 8)],
                    1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                    8'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
    end

    // Reset during the second MUL cycle drops the command.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 2'b11;
    cmd_a     = 8'h0B;
    cmd_b     = 8'h0D;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    checkOutput("mid_mul_busy", 32'(cmd_ready), 32'd0);
    reset_n = 1'b0;
    #1;
    checkResetValues("mid_reset");
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("after_reset_valid", 32'(rsp_valid), 32'd0);
      checkOutput("after_reset_ready", 32'(cmd_ready), 32'd1);
    end

    applyStimulus(2'b11, 4'b0000, 1'b0, 8'h06, 8'h07, 1);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
